matvec_fetch_engine: RTL and testbench



---
 rtl/matvec_fetch_engine_pkg.sv | 29 ++
 rtl/matvec_fetch_engine_if.sv | 22 ++
 rtl/matvec_fetch_engine_mac_lane.sv | 71 +++++++
 rtl/matvec_fetch_engine.sv | 125 ++++++++++++
 tb/tb_matvec_fetch_engine.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matvec_fetch_engine_pkg.sv
// Shared types and elaboration helpers for the matrix-vector fetch engine.
// Defines package matvec_pkg: FSM state encoding, row unpacking and width checks.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_B  = 3'd1,
    WAIT_B = 3'd2,
    REQ_A  = 3'd3,
    WAIT_A = 3'd4,
    EXEC   = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic int row_width(input int data_width, input int num_lanes);
    return data_width * num_lanes;
  endfunction

  // Element 0 sits in the most significant slot of a memory word.
  function automatic int elem_lsb(input int k, input int num_lanes, input int data_width);
    return (num_lanes - 1 - k) * data_width;
  endfunction

  function automatic bit acc_width_ok(input int acc_width, input int data_width,
                                      input int num_lanes);
    return acc_width >= 2 * data_width + $clog2(num_lanes);
  endfunction

endpackage

// File: rtl/matvec_fetch_engine_if.sv
// Memory-mapped read port between the engine (master) and the memory wrapper (slave).
// Handshake: a request is accepted on the clock edge where mem_read=1 and mem_waitrequest=0.
interface matvec_fetch_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROW_WIDTH  = 64
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic [ROW_WIDTH-1:0]  mem_readdata;
  logic                  mem_readdatavalid;
  logic                  mem_waitrequest;

  modport master (
    output mem_address, mem_read,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_readdata, mem_readdatavalid, mem_waitrequest
  );
endinterface

// File: rtl/matvec_fetch_engine_mac_lane.sv
// One row lane: a NUM_LANES-deep FIFO loaded a whole row at a time, feeding one MAC.
// MATVEC_SAT_EN selects a saturating accumulator instead of a wrapping one.
module mac_lane
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            push,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] push_row,
  input  logic                            pop,
  input  logic                            en,
  input  logic [DATA_WIDTH-1:0]           b_elem,
  output logic [ACC_WIDTH-1:0]            acc
);
  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CW = $clog2(NUM_LANES + 1);

  logic [DATA_WIDTH-1:0]   fifo [NUM_LANES];
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, fifo[rd_ptr]} * {{DATA_WIDTH{1'b0}}, b_elem};
  assign acc  = acc_q;

  // A push always lands a full row, so the read pointer restarts at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < NUM_LANES; i++) fifo[i] <= '0;
    end else if (push) begin
      rd_ptr <= '0;
      count  <= CW'(NUM_LANES);
      for (int i = 0; i < NUM_LANES; i++)
        fifo[i] <= push_row[elem_lsb(i, NUM_LANES, DATA_WIDTH) +: DATA_WIDTH];
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

`ifdef MATVEC_SAT_EN
  localparam int SW = ((ACC_WIDTH > 2 * DATA_WIDTH) ? ACC_WIDTH : 2 * DATA_WIDTH) + 1;
  logic [SW-1:0] sum_w;
  assign sum_w = SW'(acc_q) + SW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   acc_q <= '0;
    else if (clr)                                 acc_q <= '0;
    else if (en && sum_w > SW'({ACC_WIDTH{1'b1}})) acc_q <= '1;
    else if (en)                                  acc_q <= sum_w[ACC_WIDTH-1:0];
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc_q + ACC_WIDTH'(prod);
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && count != '0));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));

endmodule

// File: rtl/matvec_fetch_engine.sv
// Fetches B and NUM_ROWS rows of A, then streams B through all lanes: result[r] = sum_k A[r][k]*B[k].
// Build with MATVEC_SAT_EN defined for saturating accumulators (default: wrap mod 2^ACC_WIDTH).
module matvec_fetch_engine
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 8,
  parameter int NUM_ROWS   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int ACC_WIDTH  = 24,
  parameter int B_BASE     = 0,
  parameter int A_BASE     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  matvec_fetch_engine_if.master         mem,
  output logic [NUM_ROWS*ACC_WIDTH-1:0] result,
  output state_t                        dbg_state
);
  localparam int ROW_WIDTH = row_width(DATA_WIDTH, NUM_LANES);
  localparam int RW        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int KW        = $clog2(NUM_LANES + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

  state_t                        state_q, state_d;
  logic [RW-1:0]                 row_q;
  logic [KW-1:0]                 k_q;
  logic [ROW_WIDTH-1:0]          b_q;
  logic [NUM_ROWS*ACC_WIDTH-1:0] result_q;
  logic [NUM_ROWS*ACC_WIDTH-1:0] acc_flat;
  logic [DATA_WIDTH-1:0]         b_elem;
  logic                          start_ok, push_en, pop, exec_last;

  // A narrow accumulator without saturation is legal but wraps on large sums.
  if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH, NUM_LANES)) begin : g_acc_may_wrap
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)                   state_d = REQ_B;
      REQ_B:      if (!mem.mem_waitrequest)    state_d = WAIT_B;
      WAIT_B:     if (mem.mem_readdatavalid)   state_d = REQ_A;
      REQ_A:      if (!mem.mem_waitrequest)    state_d = WAIT_A;
      WAIT_A:     if (mem.mem_readdatavalid)   state_d = (row_q == LAST_ROW) ? EXEC : REQ_A;
      EXEC:       if (exec_last)               state_d = DONE;
      default:                                 state_d = IDLE;
    endcase
  end

  assign start_ok  = start && (state_q == IDLE || state_q == DONE);
  assign push_en   = (state_q == WAIT_A) && mem.mem_readdatavalid;
  // EXEC runs one extra cycle after the last pop so result captures the settled sums.
  assign exec_last = (state_q == EXEC) && (k_q == KW'(NUM_LANES));
  assign pop       = (state_q == EXEC) && (k_q != KW'(NUM_LANES));

  always_comb begin
    mem.mem_read    = 1'b0;
    mem.mem_address = '0;
    if (state_q == REQ_B) begin
      mem.mem_read    = 1'b1;
      mem.mem_address = ADDR_WIDTH'(B_BASE);
    end else if (state_q == REQ_A) begin
      mem.mem_read    = 1'b1;
      mem.mem_address = ADDR_WIDTH'(A_BASE) + ADDR_WIDTH'(row_q);
    end
  end

  always_comb begin
    b_elem = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (k_q == KW'(k)) b_elem = b_q[elem_lsb(k, NUM_LANES, DATA_WIDTH) +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q    <= '0;
      k_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (start_ok) begin
        row_q    <= '0;
        k_q      <= '0;
        result_q <= '0;
      end
      if (state_q == WAIT_B && mem.mem_readdatavalid) b_q <= mem.mem_readdata;
      if (push_en && row_q != LAST_ROW)               row_q <= row_q + 1'b1;
      if (pop)                                        k_q <= k_q + 1'b1;
      if (exec_last)                                  result_q <= acc_flat;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_LANES (NUM_LANES),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok),
      .push     (push_en && row_q == RW'(r)),
      .push_row (mem.mem_readdata),
      .pop      (pop),
      .en       (pop),
      .b_elem   (b_elem),
      .acc      (acc_flat[r*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matvec_fetch_engine.sv
// Directed bench for matvec_fetch_engine with a behavioural memory and a result scoreboard.
// DUT is built with ACC_WIDTH=16 so both small sums and the wrap/saturate case fit one instance.
module tb_matvec_fetch_engine;
  import matvec_pkg::*;

  localparam int DW    = 8;
  localparam int NL    = 8;
  localparam int NR    = 8;
  localparam int AW    = 32;
  localparam int ACC   = 16;
  localparam int ROW_W = DW * NL;
  localparam int RES_W = NR * ACC;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   start = 1'b0;
  logic   busy, done;
  logic [RES_W-1:0] result;
  state_t dbg_state;

  matvec_fetch_engine_if #(.ADDR_WIDTH(AW), .ROW_WIDTH(ROW_W)) mem_bus ();

  matvec_fetch_engine #(
    .DATA_WIDTH(DW), .NUM_LANES(NL), .NUM_ROWS(NR), .ADDR_WIDTH(AW),
    .ACC_WIDTH(ACC), .B_BASE(0), .A_BASE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem(mem_bus.master), .result(result), .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RES_W-1:0] exp_q [$];
  logic [AW-1:0]    reads_q [$];
  logic [ROW_W-1:0] words [16];
  int wait_cfg = 0;
  int lat_cfg  = 1;
  bit stray_req = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [RES_W-1:0] act,
                           input logic [RES_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] exp_scaled(input int mul);
    logic [RES_W-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r*ACC +: ACC] = ACC'(mul * (r + 1));
    return v;
  endfunction

  function automatic logic [RES_W-1:0] exp_const(input logic [ACC-1:0] val);
    logic [RES_W-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r*ACC +: ACC] = val;
    return v;
  endfunction

  task automatic load_words(input logic [ROW_W-1:0] b_word, input bit a_all_ff);
    words[0] = b_word;
    for (int r = 0; r < NR; r++) words[1+r] = a_all_ff ? '1 : {NL{8'(r + 1)}};
  endtask

  // memory model: decides waitrequest/readdatavalid on the negedge before each posedge
  initial begin
    int resp_cnt = 0;
    int wcnt = 0;
    bit stalled = 1'b0;
    int stall_addr = 0;
    logic [ROW_W-1:0] resp_data = '0;
    mem_bus.mem_waitrequest   = 1'b0;
    mem_bus.mem_readdatavalid = 1'b0;
    mem_bus.mem_readdata      = '0;
    forever begin
      @(negedge clk);
      mem_bus.mem_readdatavalid = 1'b0;
      if (!rst_n) begin
        resp_cnt = 0; wcnt = 0; stalled = 1'b0;
        mem_bus.mem_waitrequest = 1'b0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            mem_bus.mem_readdatavalid = 1'b1;
            mem_bus.mem_readdata      = resp_data;
          end
        end
        if (stray_req) begin
          mem_bus.mem_readdatavalid = 1'b1;
          mem_bus.mem_readdata      = '1;
          stray_req = 1'b0;
        end
        if (stalled) begin
          check_bit("stall_read_held", mem_bus.mem_read, 1'b1);
          check_int("stall_addr_held", int'(mem_bus.mem_address), stall_addr);
        end
        if (mem_bus.mem_read) begin
          if (wcnt < wait_cfg) begin
            mem_bus.mem_waitrequest = 1'b1;
            wcnt++;
            stalled = 1'b1;
            stall_addr = int'(mem_bus.mem_address);
          end else begin
            mem_bus.mem_waitrequest = 1'b0;
            wcnt = 0;
            stalled = 1'b0;
            reads_q.push_back(mem_bus.mem_address);
            resp_data = words[mem_bus.mem_address[3:0]];
            resp_cnt = lat_cfg;
          end
        end else begin
          mem_bus.mem_waitrequest = 1'b0;
          stalled = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor: compares result whenever done rises
  initial begin
    logic done_d = 1'b0;
    logic [RES_W-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with empty queue, expected none");
        end else begin
          exp_v = exp_q.pop_front();
          check_val("result", result, exp_v);
        end
      end
      done_d = done;
    end
  end

  // driver: one full run from start to done
  task automatic run(input logic [RES_W-1:0] exp, input int exp_edges, input bit poke_wait_a);
    int edges = 0;
    bit poked = 1'b0;
    bit busy_bad = 1'b0;
    bit order_bad = 1'b0;
    reads_q.delete();
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("done_cleared", done, 1'b0);
    check_val("result_cleared", result, '0);
    while (!done && edges < 2000) begin
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
      if (!done && !busy) busy_bad = 1'b1;
      if (poke_wait_a && !poked && dbg_state == WAIT_A) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    check_bit("done_reached", done, 1'b1);
    check_int("latency_edges", edges, exp_edges);
    check_bit("busy_window", busy_bad, 1'b0);
    check_bit("busy_low_in_done", busy, 1'b0);
    check_int("read_count", reads_q.size(), NR + 1);
    for (int i = 0; i < reads_q.size(); i++) if (reads_q[i] != AW'(i)) order_bad = 1'b1;
    check_bit("read_order", order_bad, 1'b0);
  endtask

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (2) @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_mem_read", mem_bus.mem_read, 1'b0);
    check_int("rst_address", int'(mem_bus.mem_address), 0);
    check_val("rst_result", result, '0);
    check_int("rst_state", int'(dbg_state), int'(IDLE));
    rst_n = 1'b1;

    // B = 1..8, A[r][*] = r+1 -> 36*(r+1)
    load_words(64'h0102030405060708, 1'b0);
    run(exp_scaled(36), 27, 1'b0);

    // wait states: 3 stall cycles, data 4 cycles after accept
    wait_cfg = 3; lat_cfg = 4;
    run(exp_scaled(36), 9 * (3 + 1 + 4) + NL + 1, 1'b0);
    wait_cfg = 0; lat_cfg = 1;

    // all 0xFF: 8*255*255 = 520200 -> wraps to 0xF008 in 16 bits, or saturates
    load_words('1, 1'b1);
`ifdef MATVEC_SAT_EN
    run(exp_const(16'hFFFF), 27, 1'b0);
`else
    run(exp_const(16'hF008), 27, 1'b0);
`endif

    // reset during EXEC cycle k=3 with 0xFF rows still partly in the FIFOs
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dbg_state != EXEC && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_int("reach_exec", int'(dbg_state), int'(EXEC));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_done", done, 1'b0);
    check_bit("mid_rst_mem_read", mem_bus.mem_read, 1'b0);
    check_int("mid_rst_address", int'(mem_bus.mem_address), 0);
    check_val("mid_rst_result", result, '0);
    check_int("mid_rst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // stray readdatavalid in IDLE must not push or move the FSM
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    check_int("stray_state", int'(dbg_state), int'(IDLE));
    check_bit("stray_busy", busy, 1'b0);

    // fresh run: B all 2, A[r][*] = r+1 -> 16*(r+1)
    load_words(64'h0202020202020202, 1'b0);
    run(exp_scaled(16), 27, 1'b0);

    // start during WAIT_A is ignored: 9 reads of 1+4 edges each, no restart
    lat_cfg = 4;
    run(exp_scaled(16), 9 * (1 + 4) + NL + 1, 1'b1);
    lat_cfg = 1;

    // start while in DONE clears result and done, then completes a new run
    load_words(64'h0102030405060708, 1'b0);
    run(exp_scaled(36), 27, 1'b0);

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
